// File: rtl/bcd_div11_pkg.sv
// rtl/bcd_div11_pkg.sv - shared types and constants for the BCD mod-11 sequencer
package bcd_div11_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STEP   = 2'd1,
        S_RESULT = 2'd2
    } state_e;

    localparam logic [3:0] MOD         = 4'd11;
    localparam int         DIGIT_W     = 4;
    localparam int         BEAT_DIGITS = 4;

    // Beats claiming more than four digits are treated as full beats.
    function automatic logic [2:0] clamp_ndig(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage

// File: rtl/div11_step.sv
// rtl/div11_step.sv - one Horner step of mod-11 reduction: r_next = (d - r) mod 11
module div11_step
    import bcd_div11_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_i,
    input  logic [DIGIT_W-1:0] r_i,
    output logic [DIGIT_W-1:0] r_next_o,
    output logic               bad_o
);

    logic [4:0] diff;

    always_comb begin
        diff  = 5'd0;
        bad_o = (d_i > 4'd9);
        if (d_i >= r_i) begin
            diff = {1'b0, d_i} - {1'b0, r_i};
        end else begin
            diff = {1'b0, d_i} + {1'b0, MOD} - {1'b0, r_i};
        end
        // A non-BCD digit leaves the running remainder untouched.
        r_next_o = bad_o ? r_i : diff[3:0];
    end

endmodule

// File: rtl/bcd_div11_seq.sv
// rtl/bcd_div11_seq.sv - streams BCD beats digit by digit and reports the number mod 11
module bcd_div11_seq
    import bcd_div11_pkg::*;
#(
    parameter  int MAX_DIGITS = 32,
    localparam int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [BEAT_DIGITS*DIGIT_W-1:0] in_data_i,
    input  logic [2:0]                     in_ndig_i,
    input  logic                           in_last_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [DIGIT_W-1:0]             res_rem_o,
    output logic                           res_div_o,
    output logic                           res_err_o,
    output logic [CW-1:0]                  res_ndig_o
);

    state_e                           state_q, state_d;
    logic [BEAT_DIGITS*DIGIT_W-1:0]   data_q, data_d;
    logic [1:0]                       idx_q, idx_d;
    logic                             last_q, last_d;
    logic [DIGIT_W-1:0]               rem_q, rem_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic                             err_q, err_d;

    logic                             accept;
    logic [2:0]                       ndig_c;
    logic [DIGIT_W-1:0]               digit;
    logic [DIGIT_W-1:0]               step_rem;
    logic                             step_bad;
    logic                             cnt_full;

    assign accept   = in_valid_i & in_ready_o;
    assign ndig_c   = clamp_ndig(in_ndig_i);
    assign digit    = data_q[{idx_q, 2'b00} +: DIGIT_W];
    assign cnt_full = (cnt_q == CW'(MAX_DIGITS));

    div11_step u_step (
        .d_i      (digit),
        .r_i      (rem_q),
        .r_next_o (step_rem),
        .bad_o    (step_bad)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (accept) begin
                    if (ndig_c != 3'd0) state_d = S_STEP;
                    else if (in_last_i) state_d = S_RESULT;
                end
            end
            S_STEP: begin
                if (idx_q == 2'd0) state_d = last_q ? S_RESULT : S_WAIT;
            end
            S_RESULT: begin
                if (res_ready_i) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == S_WAIT);
        res_valid_o = (state_q == S_RESULT);
        res_div_o   = res_valid_o && (rem_q == '0) && !err_q;
        res_rem_o   = rem_q;
        res_err_o   = err_q;
        res_ndig_o  = cnt_q;
    end

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        last_d = last_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        case (state_q)
            S_WAIT: begin
                if (accept) begin
                    data_d = in_data_i;
                    last_d = in_last_i;
                    idx_d  = ndig_c[1:0] - 2'd1;
                end
            end
            S_STEP: begin
                // Overflow digits still fold into the remainder; only the count saturates.
                rem_d = step_rem;
                err_d = err_q | step_bad | cnt_full;
                cnt_d = cnt_full ? cnt_q : cnt_q + CW'(1);
                idx_d = idx_q - 2'd1;
            end
            S_RESULT: begin
                if (res_ready_i) begin
                    rem_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            rem_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_div11_seq.sv
// tb/tb_bcd_div11_seq.sv - scoreboard bench for the BCD mod-11 sequencer
module tb_bcd_div11_seq;

    localparam int MAX = 32;
    localparam int CW  = 6;

    typedef struct packed {
        logic [3:0]    rem;
        logic          div;
        logic          err;
        logic [CW-1:0] ndig;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data = '0;
    logic [2:0]    in_ndig = '0;
    logic          in_last = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [3:0]    res_rem;
    logic          res_div;
    logic          res_err;
    logic [CW-1:0] res_ndig;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    res_t sb[$];
    int   m_rem = 0;
    int   m_cnt = 0;
    bit   m_err = 1'b0;

    bcd_div11_seq #(.MAX_DIGITS(MAX)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_ndig_i   (in_ndig),
        .in_last_i   (in_last),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_rem_o   (res_rem),
        .res_div_o   (res_div),
        .res_err_o   (res_err),
        .res_ndig_o  (res_ndig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(input res_t r);
        return $sformatf("rem=%0d div=%0b err=%0b ndig=%0d", r.rem, r.div, r.err, r.ndig);
    endfunction

    // Reference uses decimal accumulation (r*10+d) mod 11.
    task automatic model_beat(input logic [15:0] data, input logic [2:0] nd, input logic last);
        int         n;
        logic [3:0] d;
        res_t       e;
        n = (nd > 3'd4) ? 4 : int'(nd);
        for (int i = n - 1; i >= 0; i--) begin
            d = data[i*4 +: 4];
            if (m_cnt == MAX) m_err = 1'b1;
            else m_cnt++;
            if (d > 4'd9) m_err = 1'b1;
            else m_rem = (m_rem * 10 + int'(d)) % 11;
        end
        if (last) begin
            e.rem  = 4'(m_rem);
            e.div  = (m_rem == 0) && !m_err;
            e.err  = m_err;
            e.ndig = CW'(m_cnt);
            sb.push_back(e);
            m_rem = 0;
            m_cnt = 0;
            m_err = 1'b0;
        end
    endtask

    task automatic send_beat(input logic [15:0] data, input logic [2:0] nd, input logic last,
                             output int acc_cyc);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_ndig  = nd;
        in_last  = last;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
        end
        acc_cyc = cyc;
        model_beat(data, nd, last);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_ndig  = 3'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic collect(input int stall, output res_t obs, output int seen_cyc, output bit ok);
        int t;
        t = 0;
        while (!res_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok       = res_valid;
        seen_cyc = cyc;
        obs      = {res_rem, res_div, res_err, res_ndig};
        repeat (stall) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 6;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b, want 0", res_valid); end
        if (res_rem !== 4'd0) begin n_fail++; $display("FAIL reset_rem: got %0d, want 0", res_rem); end
        if (res_div !== 1'b0) begin n_fail++; $display("FAIL reset_div: got %b, want 0", res_div); end
        if (res_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, want 0", res_err); end
        if (res_ndig !== '0) begin n_fail++; $display("FAIL reset_ndig: got %0d, want 0", res_ndig); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_beat(input string name, input logic [15:0] data, input logic [2:0] nd,
                                    input int lat_exp);
        int   acc, seen;
        bit   ok;
        res_t obs, exp;
        send_beat(data, nd, 1'b1, acc);
        collect(0, obs, seen, ok);
        exp = sb.pop_front();
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL %s_timeout: res_valid never rose", name); end
        if (obs !== exp) begin n_fail++; $display("FAIL %s_result: got %s, want %s", name, fmt(obs), fmt(exp)); end
        if (seen - acc - 1 !== lat_exp) begin
            n_fail++; $display("FAIL %s_latency: got %0d, want %0d", name, seen - acc - 1, lat_exp);
        end
    endtask

    task automatic test_two_beats;
        int   acc, seen, lows;
        bit   ok;
        res_t obs, exp;
        send_beat(16'h1234, 3'd4, 1'b0, acc);
        lows = 0;
        while (!in_ready && lows < 20) begin
            @(negedge clk);
            lows++;
        end
        n_checks++;
        if (lows !== 4) begin n_fail++; $display("FAIL two_beat_ready_low: got %0d, want 4", lows); end
        send_beat(16'h5678, 3'd4, 1'b1, acc);
        collect(0, obs, seen, ok);
        exp = sb.pop_front();
        n_checks += 2;
        if (obs !== exp || !ok) begin n_fail++; $display("FAIL two_beat_result: got %s, want %s", fmt(obs), fmt(exp)); end
        if (seen - acc - 1 !== 4) begin n_fail++; $display("FAIL two_beat_latency: got %0d, want 4", seen - acc - 1); end
    endtask

    task automatic test_empty;
        int   acc, seen;
        bit   ok;
        res_t obs, exp;
        send_beat(16'h0000, 3'd0, 1'b1, acc);
        collect(0, obs, seen, ok);
        exp = sb.pop_front();
        n_checks += 2;
        if (obs !== exp || !ok) begin n_fail++; $display("FAIL empty_result: got %s, want %s", fmt(obs), fmt(exp)); end
        if (seen - acc - 1 !== 0) begin n_fail++; $display("FAIL empty_latency: got %0d extra cycles, want 0", seen - acc - 1); end
        // Zero-digit non-last beat is a no-op leading into a real beat.
        send_beat(16'h0000, 3'd0, 1'b0, acc);
        send_beat(16'h0011, 3'd2, 1'b1, acc);
        collect(0, obs, seen, ok);
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp || !ok) begin n_fail++; $display("FAIL empty_prefix_result: got %s, want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_overflow;
        int   acc, seen;
        bit   ok;
        res_t obs, exp;
        for (int b = 0; b < 9; b++) send_beat(16'h1234, 3'd4, (b == 8), acc);
        collect(0, obs, seen, ok);
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp || !ok) begin n_fail++; $display("FAIL overflow_result: got %s, want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_backpressure;
        int   acc, seen, t;
        bit   stable;
        res_t obs, exp, cur;
        send_beat(16'h1234, 3'd4, 1'b1, acc);
        t = 0;
        while (!res_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        obs      = {res_rem, res_div, res_err, res_ndig};
        in_valid = 1'b1;
        in_data  = 16'h0121;
        in_ndig  = 3'd3;
        in_last  = 1'b1;
        stable   = res_valid;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cur = {res_rem, res_div, res_err, res_ndig};
            if (cur !== obs || in_ready !== 1'b0 || res_valid !== 1'b1) stable = 1'b0;
        end
        exp = sb.pop_front();
        n_checks += 2;
        if (obs !== exp) begin n_fail++; $display("FAIL stall_result: got %s, want %s", fmt(obs), fmt(exp)); end
        if (!stable) begin n_fail++; $display("FAIL stall_stable: outputs moved or in_ready rose during stall, want held"); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_hs_ready: got %b, want 1", in_ready); end
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL post_hs_valid: got %b, want 0", res_valid); end
        acc = cyc;
        model_beat(16'h0121, 3'd3, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL post_hs_accept: in_ready=%b, want 0 (beat taken)", in_ready); end
        collect(0, obs, seen, stable);
        exp = sb.pop_front();
        n_checks += 2;
        if (obs !== exp || !stable) begin n_fail++; $display("FAIL post_hs_result: got %s, want %s", fmt(obs), fmt(exp)); end
        if (seen - acc - 1 !== 3) begin n_fail++; $display("FAIL post_hs_latency: got %0d, want 3", seen - acc - 1); end
    endtask

    task automatic test_reset_mid;
        int   acc, seen;
        bit   ok;
        res_t obs, exp;
        send_beat(16'h9999, 3'd4, 1'b1, acc);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b, want 1", in_ready); end
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_res_valid: got %b, want 0", res_valid); end
        if (res_rem !== 4'd0) begin n_fail++; $display("FAIL midrst_rem: got %0d, want 0", res_rem); end
        if (res_ndig !== '0) begin n_fail++; $display("FAIL midrst_ndig: got %0d, want 0", res_ndig); end
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(16'h0011, 3'd2, 1'b1, acc);
        collect(0, obs, seen, ok);
        exp = sb.pop_front();
        n_checks += 2;
        if (obs !== exp || !ok) begin n_fail++; $display("FAIL midrst_next_result: got %s, want %s", fmt(obs), fmt(exp)); end
        if (seen - acc - 1 !== 2) begin n_fail++; $display("FAIL midrst_next_latency: got %0d, want 2", seen - acc - 1); end
    endtask

    initial begin
        #2;
        test_reset();
        test_single_beat("d0121", 16'h0121, 3'd3, 3);
        test_single_beat("d1234", 16'h1234, 3'd4, 4);
        test_single_beat("ndig7", 16'h1234, 3'd7, 4);
        test_single_beat("rem10", 16'h9921, 3'd2, 2);
        test_single_beat("bad_digit", 16'h1A21, 3'd4, 4);
        test_two_beats();
        test_empty();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
